// File: rtl/reloj_bcd_if.sv
`default_nettype none
// ============================================================================
//  Module      : reloj_bcd_if
//  Description : Control, load handshake and time outputs of the BCD
//                real-time clock. The alarm signals are present only when
//                RELOJ_ALARM_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface reloj_bcd_if;
    logic       run;
    logic       set_valid;
    logic       set_ready;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic       set_err;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       sec_pulse;
`ifdef RELOJ_ALARM_EN
    logic       al_wr;
    logic [7:0] al_hh;
    logic [7:0] al_mm;
    logic       al_ack;
    logic       alarm;
`endif

    // Controller side: drives run and load requests, observes the time
    modport master (
        output run, set_valid, set_hh, set_mm, set_ss,
`ifdef RELOJ_ALARM_EN
        output al_wr, al_hh, al_mm, al_ack,
        input  alarm,
`endif
        input  set_ready, set_err, hh, mm, ss, pm, sec_pulse
    );

    // Clock side
    modport slave (
        input  run, set_valid, set_hh, set_mm, set_ss,
`ifdef RELOJ_ALARM_EN
        input  al_wr, al_hh, al_mm, al_ack,
        output alarm,
`endif
        output set_ready, set_err, hh, mm, ss, pm, sec_pulse
    );
endinterface
`default_nettype wire

// File: rtl/reloj_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : reloj_bcd
//  Description : BCD time-of-day clock with a DIV-cycle second prescaler,
//                24-hour or 12-hour (with pm flag) display, validated time
//                load over a valid/ready handshake.
//                Optional alarm comparator enabled by macro RELOJ_ALARM_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module reloj_bcd #(
    parameter int DIV    = 50000000,
    parameter int MODE24 = 1
) (
    input  wire         clk,
    input  wire         rst,
    reloj_bcd_if.slave  bus
);

    localparam int              c_PW     = $clog2(DIV);
    localparam logic [c_PW-1:0] c_PMAX   = c_PW'(DIV - 1);
    localparam logic [c_PW-1:0] c_PONE   = c_PW'(1);
    // Midnight: 00 in 24-hour display, 12 AM in 12-hour display
    localparam logic [7:0]      c_HH_RST = (MODE24 != 0) ? 8'h00 : 8'h12;

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_inc_bcd(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] f_inc_ms(input logic [7:0] v);
        return (v == 8'h59) ? 8'h00 : f_inc_bcd(v);
    endfunction

    function automatic logic f_ms_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_presc;
    logic [7:0]      r_hh;
    logic [7:0]      r_mm;
    logic [7:0]      r_ss;
    logic            r_pm;
    logic            r_ready;
    logic            r_err;
    logic            r_sec;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [7:0] w_ld_hh;
    logic       w_ld_pm;
    logic       w_hh_ok;
    logic       w_ok;
    logic       w_acc;
    logic       w_load;
    logic       w_bad;
    logic       w_tick;

    logic       w_ss_wrap;
    logic       w_mm_wrap;
    logic [7:0] w_adv_hh;
    logic [7:0] w_adv_mm;
    logic [7:0] w_adv_ss;
    logic       w_adv_pm;

    logic       w_upd;
    logic [7:0] w_nxt_hh;
    logic [7:0] w_nxt_mm;
    logic [7:0] w_nxt_ss;
    logic       w_nxt_pm;

    // Decode and range-check the load request; bit 7 of set_hh is the pm
    // flag in 12-hour mode and is discarded in 24-hour mode
    always_comb begin
        w_ld_hh = {1'b0, bus.set_hh[6:0]};
        w_ld_pm = 1'b0;
        w_hh_ok = 1'b0;
        if (MODE24 != 0) begin
            w_hh_ok = ((w_ld_hh[7:4] <= 4'd1) && (w_ld_hh[3:0] <= 4'd9)) ||
                      ((w_ld_hh[7:4] == 4'd2) && (w_ld_hh[3:0] <= 4'd3));
        end else begin
            w_ld_pm = bus.set_hh[7];
            w_hh_ok = ((w_ld_hh[7:4] == 4'd0) && (w_ld_hh[3:0] >= 4'd1) &&
                       (w_ld_hh[3:0] <= 4'd9)) ||
                      ((w_ld_hh[7:4] == 4'd1) && (w_ld_hh[3:0] <= 4'd2));
        end
        w_ok = w_hh_ok && f_ms_ok(bus.set_mm) && f_ms_ok(bus.set_ss);
    end

    // A valid accepted load wins over a coincident tick, which is dropped
    assign w_acc  = bus.set_valid && r_ready;
    assign w_load = w_acc && w_ok;
    assign w_bad  = w_acc && !w_ok;
    assign w_tick = bus.run && (r_presc == c_PMAX);

    // One-second advance with the full seconds/minutes/hours carry chain
    always_comb begin
        w_ss_wrap = (r_ss == 8'h59);
        w_mm_wrap = w_ss_wrap && (r_mm == 8'h59);
        w_adv_ss  = f_inc_ms(r_ss);
        w_adv_mm  = w_ss_wrap ? f_inc_ms(r_mm) : r_mm;
        w_adv_hh  = r_hh;
        w_adv_pm  = r_pm;
        if (w_mm_wrap) begin
            if (MODE24 != 0) begin
                w_adv_hh = (r_hh == 8'h23) ? 8'h00 : f_inc_bcd(r_hh);
            end else if (r_hh == 8'h12) begin
                // 12 -> 01 stays in the same half of the day
                w_adv_hh = 8'h01;
            end else begin
                w_adv_hh = f_inc_bcd(r_hh);
                // 11 -> 12 crosses noon or midnight
                if (r_hh == 8'h11) begin
                    w_adv_pm = ~r_pm;
                end
            end
        end
    end

    // Select the value the time registers take on this edge
    always_comb begin
        w_upd    = w_load || w_tick;
        w_nxt_hh = r_hh;
        w_nxt_mm = r_mm;
        w_nxt_ss = r_ss;
        w_nxt_pm = r_pm;
        if (w_load) begin
            w_nxt_hh = w_ld_hh;
            w_nxt_mm = bus.set_mm;
            w_nxt_ss = bus.set_ss;
            w_nxt_pm = w_ld_pm;
        end else if (w_tick) begin
            w_nxt_hh = w_adv_hh;
            w_nxt_mm = w_adv_mm;
            w_nxt_ss = w_adv_ss;
            w_nxt_pm = w_adv_pm;
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    // Second prescaler: frozen while run is low, restarted by a load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_load) begin
            r_presc <= '0;
        end else if (bus.run) begin
            r_presc <= w_tick ? '0 : (r_presc + c_PONE);
        end
    end

    // Time-of-day registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hh <= c_HH_RST;
            r_mm <= 8'h00;
            r_ss <= 8'h00;
            r_pm <= 1'b0;
        end else if (w_upd) begin
            r_hh <= w_nxt_hh;
            r_mm <= w_nxt_mm;
            r_ss <= w_nxt_ss;
            r_pm <= w_nxt_pm;
        end
    end

    // Handshake status and one-cycle event pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b1;
            r_err   <= 1'b0;
            r_sec   <= 1'b0;
        end else begin
            r_ready <= !w_load;
            r_err   <= w_bad;
            r_sec   <= w_tick && !w_load;
        end
    end

    assign bus.set_ready = r_ready;
    assign bus.set_err   = r_err;
    assign bus.hh        = r_hh;
    assign bus.mm        = r_mm;
    assign bus.ss        = r_ss;
    assign bus.pm        = r_pm;
    assign bus.sec_pulse = r_sec;

`ifdef RELOJ_ALARM_EN
    // ------------------------------------------------------------------
    // Alarm: time stored in set_hh encoding, compared against the value
    // the time registers take whenever they change
    // ------------------------------------------------------------------
    logic [7:0] r_al_hh;
    logic [7:0] r_al_mm;
    logic       r_alarm;
    logic       w_al_hit;

    assign w_al_hit = w_upd && (w_nxt_ss == 8'h00) && (w_nxt_mm == r_al_mm) &&
                      ({w_nxt_pm, w_nxt_hh[6:0]} == r_al_hh);

    // Alarm time latch and sticky alarm flag; ack/write beat a new hit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_al_hh <= c_HH_RST;
            r_al_mm <= 8'h00;
            r_alarm <= 1'b0;
        end else begin
            if (bus.al_wr) begin
                r_al_hh <= (MODE24 != 0) ? {1'b0, bus.al_hh[6:0]} : bus.al_hh;
                r_al_mm <= bus.al_mm;
            end
            if (bus.al_ack || bus.al_wr) begin
                r_alarm <= 1'b0;
            end else if (w_al_hit) begin
                r_alarm <= 1'b1;
            end
        end
    end

    assign bus.alarm = r_alarm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reloj_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reloj_bcd
//  Description : Self-checking bench for reloj_bcd. One 24-hour and one
//                12-hour instance share the same stimulus; each is compared
//                against a seconds-of-day reference. Alarm checks are built
//                when RELOJ_ALARM_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reloj_bcd;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       set_valid = 1'b0;
    logic [7:0] set_hh = 8'h00;
    logic [7:0] set_mm = 8'h00;
    logic [7:0] set_ss = 8'h00;
`ifdef RELOJ_ALARM_EN
    logic       al_wr = 1'b0;
    logic       al_ack = 1'b0;
    logic [7:0] al_hh = 8'h00;
    logic [7:0] al_mm = 8'h00;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reloj_bcd_if b24 ();
    reloj_bcd_if b12 ();

    assign b24.run = run;        assign b12.run = run;
    assign b24.set_valid = set_valid; assign b12.set_valid = set_valid;
    assign b24.set_hh = set_hh;  assign b12.set_hh = set_hh;
    assign b24.set_mm = set_mm;  assign b12.set_mm = set_mm;
    assign b24.set_ss = set_ss;  assign b12.set_ss = set_ss;
`ifdef RELOJ_ALARM_EN
    assign b24.al_wr = al_wr;    assign b12.al_wr = al_wr;
    assign b24.al_ack = al_ack;  assign b12.al_ack = al_ack;
    assign b24.al_hh = al_hh;    assign b12.al_hh = al_hh;
    assign b24.al_mm = al_mm;    assign b12.al_mm = al_mm;
`endif

    reloj_bcd #(.DIV(DIV), .MODE24(1)) u_dut24 (.clk(clk), .rst(rst), .bus(b24.slave));
    reloj_bcd #(.DIV(DIV), .MODE24(0)) u_dut12 (.clk(clk), .rst(rst), .bus(b12.slave));

    // Reference state per instance (0 = 24-hour, 1 = 12-hour):
    // time as seconds since midnight, prescaler count, status bits
    int m_t [2];
    int m_p [2];
    bit m_rdy [2];
    bit m_err [2];
    bit m_sec [2];
    int m_al [2];
    bit m_alm [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int bcd2i(input logic [7:0] v);
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9)) return -1;
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    // Seconds since midnight for a load request, or -1 when it must be rejected
    function automatic int load_secs(input int d, input logic [7:0] h,
                                     input logic [7:0] m, input logic [7:0] s);
        int hr, mi, se, h24;
        hr = bcd2i({1'b0, h[6:0]});
        mi = bcd2i(m);
        se = bcd2i(s);
        if (mi < 0 || mi > 59 || se < 0 || se > 59) return -1;
        if (d == 0) begin
            if (hr < 0 || hr > 23) return -1;
            h24 = hr;
        end else begin
            if (hr < 1 || hr > 12) return -1;
            h24 = (hr % 12) + (h[7] ? 12 : 0);
        end
        return h24 * 3600 + mi * 60 + se;
    endfunction

    function automatic logic [7:0] exp_hh(input int d, input int t);
        int h;
        h = t / 3600;
        if (d == 0) return i2bcd(h);
        return i2bcd((h % 12 == 0) ? 12 : h % 12);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_t[d] = 0; m_p[d] = 0; m_rdy[d] = 1'b1; m_err[d] = 1'b0;
            m_sec[d] = 1'b0; m_al[d] = 0; m_alm[d] = 1'b0;
        end
    endtask

    // Advance the reference across one rising edge using the current inputs
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int  lt, nt;
            bit  acc, ld, tk, hit, clr;
            lt  = load_secs(d, set_hh, set_mm, set_ss);
            acc = set_valid && m_rdy[d];
            ld  = acc && (lt >= 0);
            tk  = run && (m_p[d] == DIV - 1);
            nt  = m_t[d];
            if (ld) nt = lt;
            else if (tk) nt = (m_t[d] + 1) % 86400;
            hit = (ld || tk) && (nt == m_al[d]);
            clr = 1'b0;
`ifdef RELOJ_ALARM_EN
            clr = al_ack || al_wr;
            if (al_wr) m_al[d] = load_secs(d, al_hh, al_mm, 8'h00);
`endif
            if (clr) m_alm[d] = 1'b0;
            else if (hit) m_alm[d] = 1'b1;
            if (ld) m_p[d] = 0;
            else if (run) m_p[d] = tk ? 0 : m_p[d] + 1;
            m_err[d] = acc && (lt < 0);
            m_sec[d] = tk && !ld;
            m_rdy[d] = !ld;
            m_t[d]   = nt;
        end
    endtask

    task automatic check_dut(input int d, input logic [7:0] hh, input logic [7:0] mm,
                             input logic [7:0] ss, input logic pm, input logic rdy,
                             input logic err, input logic sec);
        string p;
        p = (d == 0) ? "m24" : "m12";
        check({p, " hh"}, hh, exp_hh(d, m_t[d]));
        check({p, " mm"}, mm, i2bcd((m_t[d] / 60) % 60));
        check({p, " ss"}, ss, i2bcd(m_t[d] % 60));
        check({p, " pm"}, pm, (d == 1) && (m_t[d] >= 12 * 3600));
        check({p, " set_ready"}, rdy, m_rdy[d]);
        check({p, " set_err"}, err, m_err[d]);
        check({p, " sec_pulse"}, sec, m_sec[d]);
    endtask

    task automatic check_all();
        check_dut(0, b24.hh, b24.mm, b24.ss, b24.pm, b24.set_ready, b24.set_err, b24.sec_pulse);
        check_dut(1, b12.hh, b12.mm, b12.ss, b12.pm, b12.set_ready, b12.set_err, b12.sec_pulse);
`ifdef RELOJ_ALARM_EN
        check("m24 alarm", b24.alarm, m_alm[0]);
        check("m12 alarm", b12.alarm, m_alm[1]);
`endif
    endtask

    // One clock cycle: inputs are already stable, sample 1 ns after the edge
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_valid = 1'b1; set_hh = h; set_mm = m; set_ss = s;
        cycle();
        set_valid = 1'b0;
    endtask

    task automatic rand_load_vals();
        int hr;
        case ($urandom_range(0, 3))
            0: begin
                set_hh = 8'($urandom); set_mm = 8'($urandom); set_ss = 8'($urandom);
            end
            default: begin
                hr = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 23) : $urandom_range(1, 12);
                set_hh = i2bcd(hr);
                set_hh[7] = 1'($urandom);
                set_mm = ($urandom_range(0, 1) == 0) ? 8'h59 : i2bcd($urandom_range(0, 59));
                case ($urandom_range(0, 2))
                    0: set_ss = 8'h58;
                    1: set_ss = 8'h59;
                    default: set_ss = i2bcd($urandom_range(0, 59));
                endcase
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        int k;
        // Asynchronous reset takes effect without a clock edge
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        rst = 1'b1;
        run = 1'b1;

        // 23:59:58 -> 23:59:59 -> 00:00:00, four cycles apart
        do_load(8'h23, 8'h59, 8'h58);
        check("load rdy low", b24.set_ready, 1'b0);
        repeat (4) cycle();
        check("t1 ss", b24.ss, 8'h59);
        check("t1 sec", b24.sec_pulse, 1'b1);
        repeat (4) cycle();
        check("wrap hh", b24.hh, 8'h00);
        check("wrap mm", b24.mm, 8'h00);
        check("wrap ss", b24.ss, 8'h00);
        check("wrap sec", b24.sec_pulse, 1'b1);

        // 12-hour: 11:59:59 AM -> 12:00:00 PM; 12:59:59 PM -> 01:00:00 PM
        do_load(8'h11, 8'h59, 8'h59);
        repeat (4) cycle();
        check("noon hh", b12.hh, 8'h12);
        check("noon pm", b12.pm, 1'b1);
        do_load(8'h92, 8'h59, 8'h59);
        repeat (4) cycle();
        check("one hh", b12.hh, 8'h01);
        check("one pm", b12.pm, 1'b1);
        check("m24 13h", b24.hh, 8'h13);

        // Rejected loads: error pulse one cycle, time kept, ready held
        run = 1'b0;
        do_load(8'h24, 8'h00, 8'h00);
        check("bad hh err", b24.set_err, 1'b1);
        check("bad hh rdy", b24.set_ready, 1'b1);
        check("bad hh keep", b24.hh, 8'h13);
        cycle();
        check("bad hh err end", b24.set_err, 1'b0);
        do_load(8'h05, 8'h10, 8'h5A);
        check("bad ss err", b12.set_err, 1'b1);
        check("bad ss keep", b12.ss, 8'h00);
        cycle();

        // Load coincident with a tick: load wins, tick discarded
        run = 1'b1;
        do_load(8'h01, 8'h02, 8'h03);
        k = 0;
        while (m_p[0] != DIV - 1 && k < 2 * DIV) begin
            cycle();
            k++;
        end
        check("tick wait bound", k < 2 * DIV, 1'b1);
        do_load(8'h10, 8'h20, 8'h30);
        check("coll hh", b24.hh, 8'h10);
        check("coll mm", b24.mm, 8'h20);
        check("coll ss", b24.ss, 8'h30);
        check("coll sec", b24.sec_pulse, 1'b0);
        check("coll rdy", b24.set_ready, 1'b0);
        cycle();
        check("coll rdy back", b24.set_ready, 1'b1);

        // Freeze for 10 cycles, then resume
        cycle();
        run = 1'b0;
        repeat (10) cycle();
        check("frozen ss", b24.ss, 8'h30);
        run = 1'b1;
        repeat (6) cycle();

        // Reset mid-count with a (bad) load pending: immediate midnight, no error
        set_valid = 1'b1; set_hh = 8'h24;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst hh", b24.hh, 8'h00);
        check("rst ss", b24.ss, 8'h00);
        check("rst hh12", b12.hh, 8'h12);
        check_all();
        @(posedge clk); #1;
        check("rst no err", b24.set_err, 1'b0);
        check_all();
        set_valid = 1'b0;
        rst = 1'b1;
        repeat (3) cycle();

`ifdef RELOJ_ALARM_EN
        // Alarm at 07:30: fires on the tick into 07:30:00, cleared by ack
        al_wr = 1'b1; al_hh = 8'h07; al_mm = 8'h30;
        cycle();
        al_wr = 1'b0;
        do_load(8'h07, 8'h29, 8'h59);
        repeat (4) cycle();
        check("alarm set", b24.alarm, 1'b1);
        check("alarm set12", b12.alarm, 1'b1);
        al_ack = 1'b1;
        cycle();
        al_ack = 1'b0;
        check("alarm ack", b24.alarm, 1'b0);
        do_load(8'h07, 8'h30, 8'h00);
        check("alarm on load", b24.alarm, 1'b1);
`endif

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 9) != 0);
            set_valid = ($urandom_range(0, 7) == 0);
            if (set_valid) rand_load_vals();
`ifdef RELOJ_ALARM_EN
            al_ack = ($urandom_range(0, 39) == 0);
            al_wr  = ($urandom_range(0, 59) == 0);
            if (al_wr) begin
                al_hh = set_hh; al_mm = set_mm;
                if ($urandom_range(0, 1) == 0) al_mm = i2bcd($urandom_range(0, 59));
            end
`endif
            cycle();
        end
        set_valid = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reloj_bcd.md
RELOJ_BCD -- requirements
Module: reloj_bcd

Interface
REQ-001 SHALL have parameter DIV, default 50000000, clk cycles per second tick (>=2).
REQ-002 SHALL have parameter MODE24, default 1, 1 = 24-hour display, 0 = 12-hour display with pm flag.
REQ-003 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port run  input  1  1 = clock advances, 0 = prescaler and time frozen.
REQ-006 SHALL have port set_valid  input  1  time-load request.
REQ-007 SHALL have port set_ready  output  1  load accepted when set_valid && set_ready.
REQ-008 SHALL have port set_hh, set_mm, set_ss  input  8 each  BCD load value, tens in [7:4], units in [3:0].
REQ-009 SHALL have port set_err  output  1  one-cycle pulse, load rejected.
REQ-010 SHALL have port hh, mm, ss  output  8 each  registered BCD time.
REQ-011 SHALL have port pm  output  1  12-hour PM flag, constant 0 when MODE24=1.
REQ-012 SHALL have port sec_pulse  output  1  one-cycle pulse on every applied second tick.

Function
REQ-013 SHALL run prescaler 0..DIV-1 while run=1; tick = prescaler at DIV-1, prescaler wraps to 0 on the same edge.
REQ-014 SHALL, on tick, increment ss within the same edge; 59->00 carries to mm; mm 59->00 carries to hh, all in one cycle.
REQ-015 SHALL, when MODE24=1, wrap 23:59:59 -> 00:00:00; hours 09->10, 19->20 as BCD.
REQ-016 SHALL, when MODE24=0, keep hh in 01..12; 11:59:59 -> 12:00:00 toggles pm; 12:59:59 -> 01:00:00 without a pm toggle.
REQ-017 SHALL never present a non-BCD nibble on hh, mm or ss.
REQ-018 SHALL assert set_ready whenever not in the cycle immediately after an accepted load.
REQ-019 SHALL validate a load: every nibble <=9; ss, mm <=59; hh <=23 (MODE24=1) or 01..12 (MODE24=0).
REQ-020 SHALL, for a valid load, update hh/mm/ss on the accepting edge, clear the prescaler, and deassert set_ready for the following cycle.
REQ-021 SHALL, in MODE24=0, take pm for a load from set_hh[7] with set_hh[6:0] used as the hour; set_hh[7] SHALL be ignored as data in MODE24=1.
REQ-022 SHALL, for an invalid load, leave time unchanged and pulse set_err on the next cycle.
REQ-023 SHALL give an accepted load priority over a simultaneous tick; that tick is discarded and sec_pulse stays 0.
REQ-024 SHALL assert sec_pulse exactly on cycles where the time advanced.

Reset
REQ-025 SHALL, on rst low, immediately clear the prescaler, set_err and sec_pulse, and drive set_ready to 1.
REQ-026 SHALL reset time to 00:00:00 when MODE24=1, and to 12:00:00 with pm=0 when MODE24=0.
REQ-027 SHALL, when reset occurs mid-load, abandon that load; no set_err results.

Configuration
REQ-028 SHALL, with RELOJ_ALARM_EN defined, add ports al_wr (in, 1), al_hh (in, 8), al_mm (in, 8), al_ack (in, 1) and alarm (out, 1).
REQ-029 SHALL, with RELOJ_ALARM_EN defined, latch al_hh/al_mm on al_wr using the same encoding as set_hh; reset value is 00:00 (MODE24=1) or 12:00 AM (MODE24=0).
REQ-030 SHALL, with RELOJ_ALARM_EN defined, set alarm when a tick produces time al_hh:al_mm:00, and hold it until al_ack or al_wr.
REQ-031 SHALL give al_ack/al_wr priority over a simultaneous set of alarm.
REQ-032 SHALL raise alarm when a load matches the alarm time.
REQ-033 SHALL, without RELOJ_ALARM_EN, omit those ports and all alarm registers.

Verification
REQ-034 SHALL cover: DIV=4, MODE24=1, load 23:59:58, run=1 -> 23:59:59 then 00:00:00 four cycles apart, sec_pulse each time.
REQ-035 SHALL cover: MODE24=0, load 11:59:59 pm=0 -> one tick later 12:00:00 pm=1; load 12:59:59 -> 01:00:00, pm unchanged.
REQ-036 SHALL cover: load hh=8'h24 (MODE24=1) or ss=8'h5A -> set_err pulse one cycle, time unchanged, set_ready stays 1.
REQ-037 SHALL cover: set_valid on the tick cycle with 10:20:30 -> time 10:20:30, sec_pulse=0, set_ready low one cycle.
REQ-038 SHALL cover: run=0 for 10 cycles -> time and prescaler frozen; rst low mid-count -> immediate 00:00:00.
REQ-039 SHALL cover, with RELOJ_ALARM_EN defined: alarm 07:30, load 07:29:59, tick -> alarm=1; al_ack -> alarm=0 next cycle.
